writeback: RTL and testbench



---
 rtl/writeback.sv | 152 +++++++++++++++
 tb/tb_writeback.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback.sv
// Writeback stage: forwards execute results to the register file and aligns/extends load data.
// Optional load-wait timeout is compiled in with WRITEBACK_LOAD_TIMEOUT_EN.
module writeback #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        ready,
  input  logic [4:0]  rd,
  input  logic        rd_value_write_enable,
  input  logic [31:0] rd_value_write_data,
  input  logic        read_issued,
  input  logic [2:0]  load_funct3,
  input  logic [1:0]  load_addr_lo,
  input  logic [31:0] system_bus_read_data,
  input  logic        system_bus_read_data_valid,
  output logic        register_file_write_enable,
  output logic [4:0]  register_file_write_addr,
  output logic [31:0] register_file_write_data,
  output logic        load_timeout
);

  localparam int unsigned RegIdxW = 5;
  localparam int unsigned XlenW   = 32;
  localparam int unsigned CountW  = 16;

  typedef enum logic [0:0] {
    IDLE      = 1'b0,
    WAIT_READ = 1'b1
  } state_t;

  state_t               state, state_next;
  logic [RegIdxW-1:0]   rd_q, rd_d;
  logic [2:0]           funct3_q, funct3_d;
  logic [1:0]           addr_lo_q, addr_lo_d;
  logic                 we_d;
  logic [RegIdxW-1:0]   waddr_d;
  logic [XlenW-1:0]     wdata_d;
  logic [XlenW-1:0]     load_value;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;

  assign ready = (state == IDLE);

  // Byte/halfword selection from the latched address, then width/sign extension.
  always_comb begin
    byte_sel = 8'(system_bus_read_data >> {addr_lo_q, 3'b000});
    half_sel = addr_lo_q[1] ? system_bus_read_data[31:16] : system_bus_read_data[15:0];
    case (funct3_q)
      3'b000:  load_value = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_value = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_value = {24'd0, byte_sel};
      3'b101:  load_value = {16'd0, half_sel};
      default: load_value = system_bus_read_data;
    endcase
  end

`ifdef WRITEBACK_LOAD_TIMEOUT_EN
  logic [CountW-1:0] count_q, count_d;
  logic              timeout_d;
`else
  // The limit only matters when the timeout counter is built.
  logic [CountW-1:0] unused_timeout_cycles;
  assign unused_timeout_cycles = CountW'(TIMEOUT_CYCLES);
  assign load_timeout = 1'b0;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_next = state;
    rd_d       = rd_q;
    funct3_d   = funct3_q;
    addr_lo_d  = addr_lo_q;
    we_d       = 1'b0;
    waddr_d    = register_file_write_addr;
    wdata_d    = register_file_write_data;
`ifdef WRITEBACK_LOAD_TIMEOUT_EN
    count_d    = count_q;
    timeout_d  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (enable) begin
          if (read_issued) begin
            rd_d       = rd;
            funct3_d   = load_funct3;
            addr_lo_d  = load_addr_lo;
            state_next = WAIT_READ;
`ifdef WRITEBACK_LOAD_TIMEOUT_EN
            count_d    = '0;
`endif
          end else begin
            we_d    = rd_value_write_enable && (rd != 5'd0);
            waddr_d = rd;
            wdata_d = rd_value_write_data;
          end
        end
      end
      WAIT_READ: begin
        if (system_bus_read_data_valid) begin
          we_d       = (rd_q != 5'd0);
          waddr_d    = rd_q;
          wdata_d    = load_value;
          state_next = IDLE;
        end
`ifdef WRITEBACK_LOAD_TIMEOUT_EN
        else if (count_q == CountW'(TIMEOUT_CYCLES - 1)) begin
          timeout_d  = 1'b1;
          state_next = IDLE;
        end else begin
          count_d = count_q + CountW'(1);
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                      <= IDLE;
      rd_q                       <= '0;
      funct3_q                   <= '0;
      addr_lo_q                  <= '0;
      register_file_write_enable <= 1'b0;
      register_file_write_addr   <= '0;
      register_file_write_data   <= '0;
    end else begin
      state                      <= state_next;
      rd_q                       <= rd_d;
      funct3_q                   <= funct3_d;
      addr_lo_q                  <= addr_lo_d;
      register_file_write_enable <= we_d;
      register_file_write_addr   <= waddr_d;
      register_file_write_data   <= wdata_d;
    end
  end

`ifdef WRITEBACK_LOAD_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q      <= '0;
      load_timeout <= 1'b0;
    end else begin
      count_q      <= count_d;
      load_timeout <= timeout_d;
    end
  end
`endif

endmodule

// File: tb/tb_writeback.sv
// Directed self-checking bench for writeback: ALU forwarding, load alignment, reset abort, optional timeout.
module tb_writeback;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        ready;
  logic [4:0]  rd;
  logic        rd_value_write_enable;
  logic [31:0] rd_value_write_data;
  logic        read_issued;
  logic [2:0]  load_funct3;
  logic [1:0]  load_addr_lo;
  logic [31:0] system_bus_read_data;
  logic        system_bus_read_data_valid;
  logic        register_file_write_enable;
  logic [4:0]  register_file_write_addr;
  logic [31:0] register_file_write_data;
  logic        load_timeout;

  int vectors = 0;
  int miscompares = 0;

  writeback #(.TIMEOUT_CYCLES(4)) dut (
    .clk                        (clk),
    .reset                      (reset),
    .enable                     (enable),
    .ready                      (ready),
    .rd                         (rd),
    .rd_value_write_enable      (rd_value_write_enable),
    .rd_value_write_data        (rd_value_write_data),
    .read_issued                (read_issued),
    .load_funct3                (load_funct3),
    .load_addr_lo               (load_addr_lo),
    .system_bus_read_data       (system_bus_read_data),
    .system_bus_read_data_valid (system_bus_read_data_valid),
    .register_file_write_enable (register_file_write_enable),
    .register_file_write_addr   (register_file_write_addr),
    .register_file_write_data   (register_file_write_data),
    .load_timeout               (load_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    enable = 1'b0; rd = 5'd0; rd_value_write_enable = 1'b0; rd_value_write_data = '0;
    read_issued = 1'b0; load_funct3 = 3'b0; load_addr_lo = 2'b0;
    system_bus_read_data = '0; system_bus_read_data_valid = 1'b0;
  endtask

  // Issue a load, return bus data 'delay' cycles after accept, check the write.
  task automatic do_load(input string tag, input logic [4:0] r, input logic [2:0] f3,
                         input logic [1:0] alo, input logic [31:0] bus, input int delay,
                         input logic [31:0] exp);
    enable = 1'b1; read_issued = 1'b1; rd = r; load_funct3 = f3; load_addr_lo = alo;
    rd_value_write_enable = 1'b1; rd_value_write_data = 32'h5555_5555;
    system_bus_read_data = 32'hBAD0_BAD0; system_bus_read_data_valid = 1'b1;
    tick();
    check({tag, "_accept_ready"}, 32'(ready), 32'd0);
    check({tag, "_accept_we"}, 32'(register_file_write_enable), 32'd0);
    // Non-load traffic offered while waiting must be ignored.
    read_issued = 1'b0; rd = 5'd9; system_bus_read_data_valid = 1'b0;
    for (int i = 1; i < delay; i++) begin
      tick();
      check({tag, "_wait_ready"}, 32'(ready), 32'd0);
      check({tag, "_wait_we"}, 32'(register_file_write_enable), 32'd0);
    end
    system_bus_read_data = bus; system_bus_read_data_valid = 1'b1;
    tick();
    check({tag, "_we"}, 32'(register_file_write_enable), (r != 5'd0) ? 32'd1 : 32'd0);
    if (r != 5'd0) begin
      check({tag, "_addr"}, 32'(register_file_write_addr), 32'(r));
      check({tag, "_data"}, register_file_write_data, exp);
    end
    check({tag, "_ready_after"}, 32'(ready), 32'd1);
    idle_inputs();
    tick();
    check({tag, "_we_drop"}, 32'(register_file_write_enable), 32'd0);
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    check("rst_we", 32'(register_file_write_enable), 32'd0);
    check("rst_addr", 32'(register_file_write_addr), 32'd0);
    check("rst_data", register_file_write_data, 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_timeout", 32'(load_timeout), 32'd0);
    reset = 1'b0;
    tick();

    // Back-to-back ALU results, including rd=0 and write-enable low.
    enable = 1'b1; rd = 5'd5; rd_value_write_enable = 1'b1; rd_value_write_data = 32'hDEAD_BEEF;
    tick();
    check("alu_we", 32'(register_file_write_enable), 32'd1);
    check("alu_addr", 32'(register_file_write_addr), 32'd5);
    check("alu_data", register_file_write_data, 32'hDEAD_BEEF);
    check("alu_ready", 32'(ready), 32'd1);
    rd = 5'd0; rd_value_write_data = 32'h0000_1234;
    tick();
    check("alu_x0_we", 32'(register_file_write_enable), 32'd0);
    rd = 5'd7; rd_value_write_enable = 1'b0; rd_value_write_data = 32'h0BAD_F00D;
    tick();
    check("alu_nowe_we", 32'(register_file_write_enable), 32'd0);
    rd = 5'd31; rd_value_write_enable = 1'b1; rd_value_write_data = 32'h0000_0001;
    tick();
    check("alu31_we", 32'(register_file_write_enable), 32'd1);
    check("alu31_addr", 32'(register_file_write_addr), 32'd31);
    check("alu31_data", register_file_write_data, 32'h0000_0001);
    idle_inputs();
    tick();
    check("idle_we", 32'(register_file_write_enable), 32'd0);

    // Stray bus data in IDLE is dropped.
    system_bus_read_data = 32'hFFFF_FFFF; system_bus_read_data_valid = 1'b1;
    tick();
    check("stray_we", 32'(register_file_write_enable), 32'd0);
    idle_inputs();

    do_load("lb",   5'd3,  3'b000, 2'd2, 32'h0080_0000, 3, 32'hFFFF_FF80);
    do_load("lhu",  5'd4,  3'b101, 2'd2, 32'h8001_FFFF, 2, 32'h0000_8001);
    do_load("lh",   5'd6,  3'b001, 2'd0, 32'h0000_7FFF, 1, 32'h0000_7FFF);
    do_load("lw",   5'd8,  3'b010, 2'd1, 32'hCAFE_F00D, 2, 32'hCAFE_F00D);
    do_load("lbu",  5'd10, 3'b100, 2'd3, 32'h9A00_0000, 1, 32'h0000_009A);
    do_load("lb1",  5'd11, 3'b000, 2'd1, 32'h0000_7F00, 2, 32'h0000_007F);
    do_load("lh3",  5'd12, 3'b001, 2'd3, 32'h8000_0000, 1, 32'hFFFF_8000);
    do_load("f111", 5'd13, 3'b111, 2'd2, 32'h1122_3344, 1, 32'h1122_3344);
    do_load("lwx0", 5'd0,  3'b010, 2'd0, 32'h7777_7777, 2, 32'h0);

    // Reset while waiting for load data: abandon, later data dropped.
    enable = 1'b1; read_issued = 1'b1; rd = 5'd14; load_funct3 = 3'b010;
    tick();
    check("rstw_ready_wait", 32'(ready), 32'd0);
    idle_inputs();
    reset = 1'b1;
    #1;
    check("rstw_ready_async", 32'(ready), 32'd1);
    tick();
    reset = 1'b0;
    system_bus_read_data = 32'h1357_9BDF; system_bus_read_data_valid = 1'b1;
    tick();
    check("rstw_we", 32'(register_file_write_enable), 32'd0);
    check("rstw_ready", 32'(ready), 32'd1);
    check("rstw_timeout", 32'(load_timeout), 32'd0);
    idle_inputs();
    tick();

`ifdef WRITEBACK_LOAD_TIMEOUT_EN
    // No data: pulse after the 4th wait cycle.
    enable = 1'b1; read_issued = 1'b1; rd = 5'd15; load_funct3 = 3'b010;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("to_wait_ready", 32'(ready), 32'd0);
      check("to_wait_pulse", 32'(load_timeout), 32'd0);
    end
    tick();
    check("to_pulse", 32'(load_timeout), 32'd1);
    check("to_we", 32'(register_file_write_enable), 32'd0);
    check("to_ready", 32'(ready), 32'd1);
    tick();
    check("to_pulse_end", 32'(load_timeout), 32'd0);

    // Data in the 4th wait cycle wins over the limit.
    enable = 1'b1; read_issued = 1'b1; rd = 5'd16; load_funct3 = 3'b010;
    tick();
    idle_inputs();
    for (int i = 0; i < 3; i++) tick();
    system_bus_read_data = 32'h2468_ACE0; system_bus_read_data_valid = 1'b1;
    tick();
    check("tov_pulse", 32'(load_timeout), 32'd0);
    check("tov_we", 32'(register_file_write_enable), 32'd1);
    check("tov_data", register_file_write_data, 32'h2468_ACE0);
    idle_inputs();
    tick();
    check("tov_pulse_after", 32'(load_timeout), 32'd0);
`else
    // Without the timeout a load waits indefinitely.
    enable = 1'b1; read_issued = 1'b1; rd = 5'd15; load_funct3 = 3'b010;
    tick();
    idle_inputs();
    for (int i = 0; i < 300; i++) tick();
    check("nto_ready", 32'(ready), 32'd0);
    check("nto_pulse", 32'(load_timeout), 32'd0);
    system_bus_read_data = 32'h0F0F_0F0F; system_bus_read_data_valid = 1'b1;
    tick();
    check("nto_we", 32'(register_file_write_enable), 32'd1);
    check("nto_data", register_file_write_data, 32'h0F0F_0F0F);
    idle_inputs();
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
